vga_pic_bounce: RTL and testbench

//  Pixel source directly upstream of the VGA timing controller. Takes the controller's
//  pix_x/pix_y request coordinates and returns pix_data (RGB565) one vga_clk later,

---
 rtl/vga_pic_bounce.sv | 135 +++++++++++++
 tb/tb_vga_pic_bounce.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vga_pic_bounce.sv
// Colour-bar pattern with a bouncing square; pix_data lags pix_x/pix_y by one vga_clk.
// Optional one-pixel-pair white frame around the active area via `define VGA_PIC_BORDER_EN.
module vga_pic_bounce #(
  parameter int          H_VALID   = 640,
  parameter int          V_VALID   = 480,
  parameter int          BOX_SIZE  = 64,
  parameter int          STEP      = 4,
  parameter logic [15:0] BOX_COLOR = 16'hFC00
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pause,
  output logic [15:0] pix_data,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic [7:0]  frame_cnt
);

  localparam logic [10:0] H_VALID_C = 11'(H_VALID);
  localparam logic [10:0] V_VALID_C = 11'(V_VALID);
  localparam logic [10:0] BOX_C     = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_C    = 11'(STEP);
  localparam logic [10:0] X_LIM_C   = 11'(H_VALID - BOX_SIZE);
  localparam logic [10:0] Y_LIM_C   = 11'(V_VALID - BOX_SIZE);
  localparam logic [10:0] BAR_W_C   = 11'(H_VALID / 8);

  logic [15:0] pix_data_r;
  logic [9:0]  box_x_r;
  logic [9:0]  box_y_r;
  logic [7:0]  frame_cnt_r;
  logic        dir_x_r;
  logic        dir_y_r;

  logic [10:0] px_s;
  logic [10:0] py_s;
  logic        valid_s;
  logic        in_box_s;
  logic        border_s;
  logic        frame_end_s;
  logic [15:0] bar_color_s;
  logic [15:0] pix_next_s;
  logic [10:0] nx_s;
  logic [10:0] ny_s;

  // Returns {new_dir, new_pos}; dir 1 means moving towards larger coordinates.
  function automatic logic [10:0] next_pos(input logic [9:0] pos, input logic dir,
                                           input logic [10:0] lim);
    logic [10:0] sum;
    logic [10:0] diff;
    sum  = {1'b0, pos} + STEP_C;
    diff = {1'b0, pos} - STEP_C;
    if (dir) begin
      if (sum >= lim) next_pos = {1'b0, lim[9:0]};
      else            next_pos = {1'b1, sum[9:0]};
    end else begin
      if ({1'b0, pos} <= STEP_C) next_pos = {1'b1, 10'd0};
      else                       next_pos = {1'b0, diff[9:0]};
    end
  endfunction

  assign px_s        = {1'b0, pix_x};
  assign py_s        = {1'b0, pix_y};
  assign valid_s     = (pix_x != 10'h3FF) && (pix_y != 10'h3FF) &&
                       (px_s < H_VALID_C) && (py_s < V_VALID_C);
  assign in_box_s    = (px_s >= {1'b0, box_x_r}) && (px_s < ({1'b0, box_x_r} + BOX_C)) &&
                       (py_s >= {1'b0, box_y_r}) && (py_s < ({1'b0, box_y_r} + BOX_C));
  assign frame_end_s = (px_s == (H_VALID_C - 11'd1)) && (py_s == (V_VALID_C - 11'd1));
  assign nx_s        = next_pos(box_x_r, dir_x_r, X_LIM_C);
  assign ny_s        = next_pos(box_y_r, dir_y_r, Y_LIM_C);

`ifdef VGA_PIC_BORDER_EN
  assign border_s = (px_s <= 11'd1) || (px_s >= (H_VALID_C - 11'd2)) ||
                    (py_s <= 11'd1) || (py_s >= (V_VALID_C - 11'd2));
`else
  assign border_s = 1'b0;
`endif

  // Bar colour by comparator ladder on X.
  always_comb begin
    bar_color_s = 16'h0000;
    if      (px_s < BAR_W_C)          bar_color_s = 16'hFFFF;
    else if (px_s < (BAR_W_C * 11'd2)) bar_color_s = 16'hFFE0;
    else if (px_s < (BAR_W_C * 11'd3)) bar_color_s = 16'h07FF;
    else if (px_s < (BAR_W_C * 11'd4)) bar_color_s = 16'h07E0;
    else if (px_s < (BAR_W_C * 11'd5)) bar_color_s = 16'hF81F;
    else if (px_s < (BAR_W_C * 11'd6)) bar_color_s = 16'hF800;
    else if (px_s < (BAR_W_C * 11'd7)) bar_color_s = 16'h001F;
    else                               bar_color_s = 16'h0000;
  end

  // Pixel priority: out of range, then border, then square, then bars.
  always_comb begin
    pix_next_s = 16'h0000;
    if      (!valid_s) pix_next_s = 16'h0000;
    else if (border_s) pix_next_s = 16'hFFFF;
    else if (in_box_s) pix_next_s = BOX_COLOR;
    else               pix_next_s = bar_color_s;
  end

  // Pixel register plus square motion, which only changes on the frame-end pixel.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_data_r  <= 16'h0000;
      box_x_r     <= 10'd0;
      box_y_r     <= 10'd0;
      frame_cnt_r <= 8'd0;
      dir_x_r     <= 1'b1;
      dir_y_r     <= 1'b1;
    end else begin
      pix_data_r <= pix_next_s;
      if (frame_end_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
        if (!pause) begin
          dir_x_r <= nx_s[10];
          box_x_r <= nx_s[9:0];
          dir_y_r <= ny_s[10];
          box_y_r <= ny_s[9:0];
        end else begin
          dir_x_r <= dir_x_r;
          dir_y_r <= dir_y_r;
        end
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  assign pix_data  = pix_data_r;
  assign box_x     = box_x_r;
  assign box_y     = box_y_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_vga_pic_bounce.sv
// Directed bench for vga_pic_bounce: pixel colours, bounce positions, pause, wrap, async reset.
module tb_vga_pic_bounce;

  logic        vga_clk;
  logic        sys_rst_n;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pause;
  logic [15:0] pix_data;
  logic [9:0]  box_x;
  logic [9:0]  box_y;
  logic [7:0]  frame_cnt;

  int n_compared;
  int n_mismatched;

  vga_pic_bounce dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pause     (pause),
    .pix_data  (pix_data),
    .box_x     (box_x),
    .box_y     (box_y),
    .frame_cnt (frame_cnt)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_compared = n_compared + 1;
    if (obs !== exp) begin
      n_mismatched = n_mismatched + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one coordinate, clock it in, and settle 1 ns past the edge.
  task automatic drive(input logic [9:0] x, input logic [9:0] y);
    pix_x = x;
    pix_y = y;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) drive(10'd639, 10'd479);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    sys_rst_n    = 1'b0;
    pix_x        = 10'h3FF;
    pix_y        = 10'h3FF;
    pause        = 1'b0;
    repeat (2) @(posedge vga_clk);
    #1;
    check_eq("rst_pix",   pix_data, 16'h0000);
    check_eq("rst_box_x", {6'd0, box_x}, 16'd0);
    check_eq("rst_box_y", {6'd0, box_y}, 16'd0);
    check_eq("rst_cnt",   {8'd0, frame_cnt}, 16'd0);
    sys_rst_n = 1'b1;

    // Square at (0,0)
    drive(10'd0, 10'd0);
`ifdef VGA_PIC_BORDER_EN
    check_eq("px_0_0", pix_data, 16'hFFFF);
`else
    check_eq("px_0_0", pix_data, 16'hFC00);
`endif
    drive(10'd100, 10'd200); check_eq("bar1",      pix_data, 16'hFFE0);
    drive(10'd63,  10'd63);  check_eq("box_edge",  pix_data, 16'hFC00);
    drive(10'd64,  10'd10);  check_eq("box_right", pix_data, 16'hFFFF);
    drive(10'd10,  10'd64);  check_eq("box_below", pix_data, 16'hFFFF);
    drive(10'h3FF, 10'd50);  check_eq("no_req",    pix_data, 16'h0000);
    drive(10'd50, 10'h3FF);  check_eq("no_req_y",  pix_data, 16'h0000);
`ifdef VGA_PIC_BORDER_EN
    drive(10'd639, 10'd300); check_eq("bar7_end",  pix_data, 16'hFFFF);
`else
    drive(10'd639, 10'd300); check_eq("bar7_end",  pix_data, 16'h0000);
`endif
    drive(10'd640, 10'd100); check_eq("x_oob",     pix_data, 16'h0000);
    drive(10'd100, 10'd480); check_eq("y_oob",     pix_data, 16'h0000);
    drive(10'd160, 10'd300); check_eq("bar2",      pix_data, 16'h07FF);
    drive(10'd240, 10'd300); check_eq("bar3",      pix_data, 16'h07E0);
    drive(10'd320, 10'd300); check_eq("bar4",      pix_data, 16'hF81F);
    drive(10'd479, 10'd300); check_eq("bar5",      pix_data, 16'hF800);
    drive(10'd480, 10'd300); check_eq("bar6",      pix_data, 16'h001F);
    drive(10'd560, 10'd300); check_eq("bar7",      pix_data, 16'h0000);
    check_eq("no_move", {6'd0, box_x}, 16'd0);

    // First frame end
    drive(10'd639, 10'd479);
    check_eq("f1_box_x", {6'd0, box_x}, 16'd4);
    check_eq("f1_box_y", {6'd0, box_y}, 16'd4);
    check_eq("f1_cnt",   {8'd0, frame_cnt}, 16'd1);
    drive(10'd3, 10'd3);     check_eq("f1_outside", pix_data, 16'hFFFF);
    drive(10'd4, 10'd4);     check_eq("f1_inside",  pix_data, 16'hFC00);

    // Y reaches the bottom after 104 frames
    frames(103);
    check_eq("f104_box_y", {6'd0, box_y}, 16'd416);
    check_eq("f104_box_x", {6'd0, box_x}, 16'd416);
    drive(10'd416, 10'd416); check_eq("f104_in",   pix_data, 16'hFC00);
    drive(10'd415, 10'd416); check_eq("f104_left", pix_data, 16'hF800);
    drive(10'd479, 10'd479); check_eq("f104_corner", pix_data, 16'hFC00);
    frames(1);
    check_eq("f105_box_y", {6'd0, box_y}, 16'd412);
    check_eq("f105_box_x", {6'd0, box_x}, 16'd420);

    // X reaches the right edge after 144 frames
    frames(39);
    check_eq("f144_box_x", {6'd0, box_x}, 16'd576);
    check_eq("f144_box_y", {6'd0, box_y}, 16'd256);
    frames(1);
    check_eq("f145_box_x", {6'd0, box_x}, 16'd572);
    check_eq("f145_box_y", {6'd0, box_y}, 16'd252);
    check_eq("f145_cnt",   {8'd0, frame_cnt}, 16'd145);

    // Paused frames still count
    pause = 1'b1;
    frames(3);
    check_eq("pause_box_x", {6'd0, box_x}, 16'd572);
    check_eq("pause_box_y", {6'd0, box_y}, 16'd252);
    check_eq("pause_cnt",   {8'd0, frame_cnt}, 16'd148);
    frames(108);
    check_eq("cnt_wrap",    {8'd0, frame_cnt}, 16'd0);
    check_eq("wrap_box_x",  {6'd0, box_x}, 16'd572);
    pause = 1'b0;
    frames(1);
    check_eq("resume_box_x", {6'd0, box_x}, 16'd568);
    check_eq("resume_box_y", {6'd0, box_y}, 16'd248);

    // Asynchronous reset between edges
    drive(10'd570, 10'd250);
    check_eq("pre_rst_pix", pix_data, 16'hFC00);
    #5;
    sys_rst_n = 1'b0;
    #2;
    check_eq("arst_pix",   pix_data, 16'h0000);
    check_eq("arst_box_x", {6'd0, box_x}, 16'd0);
    check_eq("arst_box_y", {6'd0, box_y}, 16'd0);
    check_eq("arst_cnt",   {8'd0, frame_cnt}, 16'd0);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    frames(1);
    check_eq("post_rst_x", {6'd0, box_x}, 16'd4);
    check_eq("post_rst_y", {6'd0, box_y}, 16'd4);

    drive(10'd1, 10'd1);
`ifdef VGA_PIC_BORDER_EN
    check_eq("px_1_1", pix_data, 16'hFFFF);
`else
    check_eq("px_1_1", pix_data, 16'hFFFF);
`endif
    drive(10'd5, 10'd5);
`ifdef VGA_PIC_BORDER_EN
    check_eq("px_5_5", pix_data, 16'hFC00);
`else
    check_eq("px_5_5", pix_data, 16'hFC00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
